stopwatch_ctrl_fsm: RTL

Parametrised multi-channel run/stop/clear controller for the watch display path. It sits between the debounced button stage and the time-select/FND stage. It runs NUM_CH independent stopwatch channels and selects one of them for display and control. It optionally accepts single-byte ASCII commands from the UART RX FIFO.

---
 rtl/watch_pkg.sv | 43 ++++
 rtl/uart_cmd_decoder.sv | 57 +++++
 rtl/stopwatch_ctrl_fsm.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// Shared types and ASCII command constants for the stopwatch control path.
package watch_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    CLR  = 2'd2
  } ch_state_e;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_RUN  = 3'd1,
    CMD_CLR  = 3'd2,
    CMD_CHG  = 3'd3,
    CMD_SEL  = 3'd4
  } cmd_e;

  localparam logic [7:0] ASCII_R_UP = 8'h52;
  localparam logic [7:0] ASCII_R_LO = 8'h72;
  localparam logic [7:0] ASCII_C_UP = 8'h43;
  localparam logic [7:0] ASCII_C_LO = 8'h63;
  localparam logic [7:0] ASCII_M_UP = 8'h4D;
  localparam logic [7:0] ASCII_M_LO = 8'h6D;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;

  // Digits map to CMD_SEL; range against the channel count is checked by the caller.
  function automatic cmd_e decode_byte(input logic [7:0] b);
    cmd_e res;
    res = CMD_NONE;
    if (b == ASCII_R_UP || b == ASCII_R_LO) begin
      res = CMD_RUN;
    end else if (b == ASCII_C_UP || b == ASCII_C_LO) begin
      res = CMD_CLR;
    end else if (b == ASCII_M_UP || b == ASCII_M_LO) begin
      res = CMD_CHG;
    end else if (b >= ASCII_0 && b <= ASCII_9) begin
      res = CMD_SEL;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder.sv
// UART FIFO read handshake and single-byte command decode; emits a one-cycle command.
module uart_cmd_decoder
  import watch_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  input  logic       hold,
  output logic       rd_en,
  output cmd_e       cmd,
  output logic [3:0] arg,
  output logic       cmd_err
);

  logic rd_en_q, rd_en_d;
  logic data_vld_q, data_vld_d;
  logic cmd_err_q, cmd_err_d;
  cmd_e byte_cmd;
  logic [3:0] digit;

  always_comb begin
    byte_cmd   = decode_byte(rx_data);
    digit      = 4'(rx_data - ASCII_0);
    cmd        = CMD_NONE;
    arg        = digit;
    cmd_err_d  = 1'b0;
    if (data_vld_q) begin
      if (byte_cmd == CMD_NONE || (byte_cmd == CMD_SEL && 32'(digit) >= NUM_CH)) begin
        cmd_err_d = 1'b1;
      end else begin
        cmd = byte_cmd;
      end
    end
    data_vld_d = rd_en_q;
    // No back-to-back reads, and no new read while a command is parked.
    rd_en_d    = !rx_empty && !rd_en_q && !hold;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_q    <= 1'b0;
      data_vld_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      rd_en_q    <= rd_en_d;
      data_vld_q <= data_vld_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign rd_en   = rd_en_q;
  assign cmd_err = cmd_err_q;

endmodule

// File: rtl/stopwatch_ctrl_fsm.sv
// Multi-channel run/stop/clear controller with channel select.
// Define UART_CMD_EN to compile in the UART command path.
module stopwatch_ctrl_fsm
  import watch_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_run_stop,
  input  logic              btn_clear,
  input  logic              btn_change,
  input  logic [7:0]        rx_data,
  input  logic              rx_empty,
  output logic              rd_en,
  output logic [NUM_CH-1:0] enable,
  output logic [NUM_CH-1:0] clear,
  output logic [CH_W-1:0]   sel,
  output logic              cmd_err
);

  cmd_e       act_cmd;
  logic [3:0] act_arg;
  logic       pend_q;
  cmd_e       pend_cmd_q;
  logic [3:0] pend_arg_q;
  cmd_e       dec_cmd;
  logic [3:0] dec_arg;
  logic [CH_W-1:0] sel_q, sel_d;

`ifdef UART_CMD_EN
  logic       btn_any;
  logic       pend_d;
  cmd_e       pend_cmd_d;
  logic [3:0] pend_arg_d;

  assign btn_any = btn_run_stop | btn_clear | btn_change;

  uart_cmd_decoder #(
    .NUM_CH (NUM_CH)
  ) u_uart_cmd_decoder (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_empty (rx_empty),
    .hold     (pend_d),
    .rd_en    (rd_en),
    .cmd      (dec_cmd),
    .arg      (dec_arg),
    .cmd_err  (cmd_err)
  );

  // A decoded command colliding with any button is parked until a button-free cycle.
  always_comb begin
    pend_d     = pend_q;
    pend_cmd_d = pend_cmd_q;
    pend_arg_d = pend_arg_q;
    if (pend_q) begin
      pend_d = btn_any;
    end else if (dec_cmd != CMD_NONE && btn_any) begin
      pend_d     = 1'b1;
      pend_cmd_d = dec_cmd;
      pend_arg_d = dec_arg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= 1'b0;
      pend_cmd_q <= CMD_NONE;
      pend_arg_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_cmd_q <= pend_cmd_d;
      pend_arg_q <= pend_arg_d;
    end
  end
`else
  logic unused_uart;
  assign unused_uart = ^{rx_data, rx_empty};
  assign rd_en       = 1'b0;
  assign cmd_err     = 1'b0;
  assign dec_cmd     = CMD_NONE;
  assign dec_arg     = '0;
  assign pend_q      = 1'b0;
  assign pend_cmd_q  = CMD_NONE;
  assign pend_arg_q  = '0;
`endif

  // Only the highest-priority source acts in a given cycle.
  always_comb begin
    act_cmd = CMD_NONE;
    act_arg = '0;
    if (btn_clear) begin
      act_cmd = CMD_CLR;
    end else if (btn_run_stop) begin
      act_cmd = CMD_RUN;
    end else if (btn_change) begin
      act_cmd = CMD_CHG;
    end else if (pend_q) begin
      act_cmd = pend_cmd_q;
      act_arg = pend_arg_q;
    end else begin
      act_cmd = dec_cmd;
      act_arg = dec_arg;
    end
  end

  always_comb begin
    sel_d = sel_q;
    if (act_cmd == CMD_CHG) begin
      sel_d = (sel_q == CH_W'(NUM_CH - 1)) ? '0 : sel_q + CH_W'(1);
    end else if (act_cmd == CMD_SEL) begin
      sel_d = CH_W'(act_arg);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign sel = sel_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e state_q, state_d;
    logic      hit;

    assign hit = (sel_q == CH_W'(i));

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        STOP: begin
          if (hit && act_cmd == CMD_CLR) begin
            state_d = CLR;
          end else if (hit && act_cmd == CMD_RUN) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (hit && act_cmd == CMD_RUN) begin
            state_d = STOP;
          end
        end
        default: state_d = STOP;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= STOP;
      end else begin
        state_q <= state_d;
      end
    end

    assign enable[i] = (state_q == RUN);
    assign clear[i]  = (state_q == CLR);
  end

endmodule
